// File: rtl/mux_arb_n_to_1.sv
// Registered N:1 selector (fixed-select or round-robin); out is valid the cycle after an input transfer.
// Single-entry output register reloads as it drains; every in_ready is low while the held word is stalled.
module mux_arb_n_to_1 #(
   parameter int WIDTH = 16,
   parameter int N     = 16,
   parameter int SEL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] In,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   S,
   output logic [WIDTH-1:0]   out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_src
);

   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_src;
   logic [SEL_W-1:0] r_ptr;

   logic             w_can_load;
   logic             w_xfer;
   logic             w_fix_vld;
   logic [SEL_W-1:0] w_fix;
   logic             w_hi_vld;
   logic [SEL_W-1:0] w_hi;
   logic             w_lo_vld;
   logic [SEL_W-1:0] w_lo;
   logic             w_grant_vld;
   logic [SEL_W-1:0] w_grant;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic [WIDTH-1:0] w_data;

   // Round-robin: lowest requester at or above ptr, else lowest requester overall.
   always_comb begin
      w_fix_vld = 1'b0;
      w_fix     = '0;
      w_hi_vld  = 1'b0;
      w_hi      = '0;
      w_lo_vld  = 1'b0;
      w_lo      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            w_lo_vld = 1'b1;
            w_lo     = SEL_W'(k);
            if (SEL_W'(k) >= r_ptr) begin
               w_hi_vld = 1'b1;
               w_hi     = SEL_W'(k);
            end
         end
         if (in_valid[k] && (S == SEL_W'(k))) begin
            w_fix_vld = 1'b1;
            w_fix     = SEL_W'(k);
         end
      end
      w_grant_vld = mode ? w_lo_vld : w_fix_vld;
      w_grant     = mode ? (w_hi_vld ? w_hi : w_lo) : w_fix;
   end

   assign w_can_load = !r_out_valid || out_ready;
   assign w_xfer     = !rst && w_can_load && w_grant_vld;
   assign w_ptr_nxt  = (w_grant == SEL_W'(N - 1)) ? '0 : w_grant + 1'b1;

   always_comb begin
      in_ready = '0;
      w_data   = '0;
      for (int k = 0; k < N; k++) begin
         if (w_grant == SEL_W'(k)) begin
            in_ready[k] = w_xfer;
            w_data      = In[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_src       <= '0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out       <= w_data;
         r_src       <= w_grant;
         r_out_valid <= 1'b1;
         if (mode) r_ptr <= w_ptr_nxt;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign out_src   = r_src;

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Bench for mux_arb_n_to_1: directed scenarios plus randomized traffic against a cycle model.
module tb_mux_arb_n_to_1;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         mode;
   logic [3:0]   S;
   logic [15:0]  in_valid;
   logic [15:0]  in_ready;
   logic [255:0] In;
   logic [15:0]  out;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_src;
   logic [15:0]  dat [16];

   logic         mode5;
   logic [2:0]   S5;
   logic [4:0]   in_valid5;
   logic [4:0]   in_ready5;
   logic [79:0]  In5;
   logic [15:0]  out5;
   logic         out_valid5;
   logic         out_ready5;
   logic [2:0]   out_src5;

   int n_checks = 0;
   int n_err    = 0;

   bit          m_valid;
   logic [15:0] m_out;
   int          m_src;
   int          m_ptr;

   always_comb begin
      In = '0;
      for (int k = 0; k < 16; k++) In[k*16 +: 16] = dat[k];
   end

   mux_arb_n_to_1 #(.WIDTH(16), .N(16), .SEL_W(4)) dut (
      .clk(clk), .rst(rst), .In(In), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .S(S), .out(out), .out_valid(out_valid),
      .out_ready(out_ready), .out_src(out_src)
   );

   mux_arb_n_to_1 #(.WIDTH(16), .N(5), .SEL_W(3)) dut5 (
      .clk(clk), .rst(rst), .In(In5), .in_valid(in_valid5), .in_ready(in_ready5),
      .mode(mode5), .S(S5), .out(out5), .out_valid(out_valid5),
      .out_ready(out_ready5), .out_src(out_src5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant from the rules: fixed index if requesting, else first requester scanning from ptr modulo 16.
   function automatic int model_grant(input bit md, input int s, input logic [15:0] v, input int ptr);
      if (!md) return (s < 16 && v[s]) ? s : -1;
      for (int i = 0; i < 16; i++) begin
         if (v[(ptr + i) % 16]) return (ptr + i) % 16;
      end
      return -1;
   endfunction

   task automatic step();
      int          g;
      logic [15:0] er;
      bit          load;
      @(negedge clk);
      g    = model_grant(mode, int'(S), in_valid, m_ptr);
      load = !rst && (!m_valid || out_ready) && (g >= 0);
      er   = load ? (16'(1) << g) : 16'h0000;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out", 32'(out), 32'(m_out));
      chk("out_src", 32'(out_src), 32'(m_src));
      if (rst) begin
         m_valid = 0; m_out = '0; m_src = 0; m_ptr = 0;
      end else if (load) begin
         m_out = dat[g]; m_src = g; m_valid = 1;
         if (mode) m_ptr = (g + 1) % 16;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int q[$];
      m_valid = 0; m_out = '0; m_src = 0; m_ptr = 0;
      for (int k = 0; k < 16; k++) dat[k] = 16'hA000 + 16'(k);
      In5 = '0;
      for (int k = 0; k < 5; k++) In5[k*16 +: 16] = 16'hA000 + 16'(k);
      mode5 = 0; S5 = '0; in_valid5 = '0; out_ready5 = 1;
      rst = 1; mode = 1; S = '0; in_valid = 16'hFFFF; out_ready = 1;
      @(posedge clk); #1;

      // Reset held 2 cycles with everything valid
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out", 32'(out), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      rst = 0; #1;
      chk("first_grant_rdy", 32'(in_ready), 32'h0001);
      step();
      chk("first_grant_src", 32'(out_src), 0);
      chk("first_grant_out", 32'(out), 32'hA000);

      // Round-robin over all 16, then wrap
      q.push_back(int'(out_src));
      repeat (16) begin step(); q.push_back(int'(out_src)); end
      for (int i = 0; i < 17; i++) chk("rr_seq", 32'(q[i]), 32'(i % 16));

      in_valid = 16'h8002;
      step(); chk("rr_alt0", 32'(out_src), 1);
      step(); chk("rr_alt1", 32'(out_src), 15);
      step(); chk("rr_alt2", 32'(out_src), 1);
      step(); chk("rr_alt3", 32'(out_src), 15);

      // Fixed select
      mode = 0; S = 4'd5; in_valid = 16'hFFFF; #1;
      chk("fix_rdy", 32'(in_ready), 32'h0020);
      step();
      chk("fix_out", 32'(out), 32'hA005);
      chk("fix_src", 32'(out_src), 5);
      in_valid = 16'hFFDF; #1;
      chk("fix_norq_rdy", 32'(in_ready), 0);
      step();
      chk("fix_drain_vld", 32'(out_valid), 0);
      chk("fix_hold_src", 32'(out_src), 5);

      // Backpressure
      S = 4'd3; in_valid = 16'hFFFF;
      step();
      chk("bp_load", 32'(out), 32'hA003);
      out_ready = 0; S = 4'd7;
      repeat (4) begin
         #1;
         chk("bp_rdy", 32'(in_ready), 0);
         step();
         chk("bp_out", 32'(out), 32'hA003);
         chk("bp_vld", 32'(out_valid), 1);
      end
      out_ready = 1; #1;
      chk("bp_release_rdy", 32'(in_ready), 32'h0080);
      step();
      chk("bp_release_out", 32'(out), 32'hA007);

      // Mid-operation reset
      mode = 1; rst = 1; step(); rst = 0;
      repeat (7) step();
      chk("mid_src6", 32'(out_src), 6);
      rst = 1; #1;
      chk("mid_rst_rdy", 32'(in_ready), 0);
      step();
      chk("mid_rst_vld", 32'(out_valid), 0);
      rst = 0;
      step();
      chk("mid_after_src", 32'(out_src), 0);

      // Pointer retained across mode switch
      repeat (8) step();
      chk("ms_src8", 32'(out_src), 8);
      mode = 0; S = 4'd2;
      step(); step();
      chk("ms_fix_src", 32'(out_src), 2);
      mode = 1;
      step();
      chk("ms_resume_src", 32'(out_src), 9);

      // N=5 instance
      in_valid = '0;
      mode5 = 1; in_valid5 = 5'h1F;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("n5_src", 32'(out_src5), 32'(i % 5));
         chk("n5_out", 32'(out5), 32'(16'hA000 + 16'(i % 5)));
      end
      mode5 = 0; S5 = 3'd6; #1;
      chk("n5_s6_rdy", 32'(in_ready5), 0);
      S5 = 3'd4; #1;
      chk("n5_s4_rdy", 32'(in_ready5), 32'h10);
      in_valid5 = '0;

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         rst       = ($urandom_range(0, 49) == 0);
         mode      = 1'($urandom_range(0, 1));
         S         = 4'($urandom_range(0, 15));
         in_valid  = 16'($urandom) & 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 16; k++) dat[k] = 16'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
